// File: rtl/decode_stage.sv
// MIPS instruction-decode stage: registered ID/EX bundle behind a valid/ready handshake,
// with load-use bubble insertion, branch flush, illegal-opcode flagging and a bubble counter.
module decode_stage #(
    parameter int IWIDTH       = 32,
    parameter int DWIDTH       = 32,
    parameter int AWIDTH       = 5,
    parameter int JR_LINK_ONLY = 0,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 ds_clk,
    input  logic                 ds_rst,
    input  logic                 ds_i_valid,
    output logic                 ds_o_ready,
    input  logic [IWIDTH-1:0]    ds_i_instr,
    input  logic                 ds_i_flush,
    input  logic                 ds_i_ready,
    output logic                 ds_o_valid,
    output logic [5:0]           ds_o_opcode,
    output logic [5:0]           ds_o_funct,
    output logic [AWIDTH-1:0]    ds_o_addr_rs,
    output logic [AWIDTH-1:0]    ds_o_addr_rt,
    output logic [AWIDTH-1:0]    ds_o_addr_wr,
    output logic [DWIDTH-1:0]    ds_o_imm,
    output logic [25:0]          ds_o_jal_addr,
    output logic                 ds_o_reg_wr,
    output logic                 ds_o_alu_src,
    output logic                 ds_o_memwrite,
    output logic                 ds_o_memtoreg,
    output logic                 ds_o_branch,
    output logic                 ds_o_jal,
    output logic                 ds_o_jr,
    output logic                 ds_o_illegal,
    output logic [CNT_WIDTH-1:0] ds_o_bubble_cnt
);

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LOAD  = 6'h23;
    localparam logic [5:0] OP_STORE = 6'h2B;
    localparam logic [5:0] FN_JR    = 6'h08;

    typedef struct packed {
        logic              valid;
        logic [5:0]        opcode;
        logic [5:0]        funct;
        logic [AWIDTH-1:0] rs;
        logic [AWIDTH-1:0] rt;
        logic [AWIDTH-1:0] wr;
        logic [DWIDTH-1:0] imm;
        logic [25:0]       jal_addr;
        logic              reg_wr;
        logic              alu_src;
        logic              memwrite;
        logic              memtoreg;
        logic              branch;
        logic              jal;
        logic              jr;
        logic              illegal;
    } bundle_t;

    bundle_t                bundle_reg, bundle_next, dec_bundle;
    logic [CNT_WIDTH-1:0]   cnt_reg, cnt_next;

    logic [5:0]             op, fn;
    logic [AWIDTH-1:0]      f_rs, f_rt, f_rd;
    logic [15:0]            imm16;
    logic [DWIDTH-1:0]      imm_sext, imm_zext;
    logic is_rtype, is_jr, is_alu_imm, is_zext, is_branch, is_load, is_store, is_jal;

    assign op       = ds_i_instr[31:26];
    assign fn       = ds_i_instr[5:0];
    assign f_rs     = AWIDTH'(ds_i_instr[25:21]);
    assign f_rt     = AWIDTH'(ds_i_instr[20:16]);
    assign f_rd     = AWIDTH'(ds_i_instr[15:11]);
    assign imm16    = ds_i_instr[15:0];
    assign imm_sext = {{(DWIDTH-16){imm16[15]}}, imm16};
    assign imm_zext = {{(DWIDTH-16){1'b0}}, imm16};

    assign is_jr      = (op == OP_RTYPE) && (fn == FN_JR);
    assign is_rtype   = (op == OP_RTYPE) && (fn != FN_JR);
    assign is_alu_imm = op inside {OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI};
    assign is_zext    = (op == OP_ANDI) || (op == OP_ORI);
    assign is_branch  = (op == OP_BEQ) || (op == OP_BNE);
    assign is_load    = (op == OP_LOAD);
    assign is_store   = (op == OP_STORE);
    assign is_jal     = (op == OP_JAL);

    // Source slot 0 is rs (or the forced link register for JR), slot 1 is rt.
    logic [1:0][AWIDTH-1:0] src_addr;
    logic [1:0]             src_used, src_hit;

    assign src_addr[0] = (is_jr && (JR_LINK_ONLY != 0)) ? AWIDTH'(31) : f_rs;
    assign src_addr[1] = f_rt;
    assign src_used[0] = is_rtype | is_jr | is_alu_imm | is_load | is_branch | is_store;
    assign src_used[1] = is_rtype | is_branch | is_store;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_src
            assign src_hit[gi] = src_used[gi] && (src_addr[gi] == bundle_reg.wr);
        end
    endgenerate

    logic adv, hazard;
    assign adv    = ~bundle_reg.valid | ds_i_ready;
    assign hazard = bundle_reg.valid & bundle_reg.memtoreg & (bundle_reg.wr != '0)
                  & ds_i_valid & (|src_hit);
    assign ds_o_ready = ds_i_flush | (adv & ~hazard);

    always_comb begin
        dec_bundle       = '0;
        dec_bundle.valid = 1'b1;
        if (is_rtype || is_jr) begin
            dec_bundle.opcode = op;
            dec_bundle.funct  = fn;
            dec_bundle.rs     = src_addr[0];
            dec_bundle.rt     = f_rt;
            dec_bundle.wr     = is_rtype ? f_rd : '0;
            dec_bundle.reg_wr = is_rtype;
            dec_bundle.jr     = is_jr;
        end else if (is_alu_imm || is_load) begin
            dec_bundle.opcode   = op;
            dec_bundle.rs       = f_rs;
            dec_bundle.rt       = f_rt;
            dec_bundle.wr       = f_rt;
            dec_bundle.imm      = is_zext ? imm_zext : imm_sext;
            dec_bundle.reg_wr   = 1'b1;
            dec_bundle.alu_src  = 1'b1;
            dec_bundle.memtoreg = is_load;
        end else if (is_branch || is_store) begin
            dec_bundle.opcode   = op;
            dec_bundle.rs       = f_rs;
            dec_bundle.rt       = f_rt;
            dec_bundle.imm      = imm_sext;
            dec_bundle.branch   = is_branch;
            dec_bundle.alu_src  = is_store;
            dec_bundle.memwrite = is_store;
        end else if (is_jal) begin
            dec_bundle.opcode   = op;
            dec_bundle.jal_addr = ds_i_instr[25:0];
            dec_bundle.wr       = AWIDTH'(31);
            dec_bundle.jal      = 1'b1;
            dec_bundle.reg_wr   = 1'b1;
        end else begin
            dec_bundle.illegal = 1'b1;
        end
    end

    // Flush beats everything; a stalled output holds; a bubble only counts when the stage advances.
    always_comb begin
        bundle_next = bundle_reg;
        cnt_next    = cnt_reg;
        if (ds_i_flush) begin
            bundle_next = '0;
        end else if (adv) begin
            if (hazard) begin
                bundle_next = '0;
                if (!(&cnt_reg)) cnt_next = cnt_reg + CNT_WIDTH'(1);
            end else if (ds_i_valid) begin
                bundle_next = dec_bundle;
            end else begin
                bundle_next = '0;
            end
        end
    end

    always_ff @(posedge ds_clk) begin
        if (ds_rst) begin
            bundle_reg <= '0;
            cnt_reg    <= '0;
        end else begin
            bundle_reg <= bundle_next;
            cnt_reg    <= cnt_next;
        end
    end

    assign ds_o_valid      = bundle_reg.valid;
    assign ds_o_opcode     = bundle_reg.opcode;
    assign ds_o_funct      = bundle_reg.funct;
    assign ds_o_addr_rs    = bundle_reg.rs;
    assign ds_o_addr_rt    = bundle_reg.rt;
    assign ds_o_addr_wr    = bundle_reg.wr;
    assign ds_o_imm        = bundle_reg.imm;
    assign ds_o_jal_addr   = bundle_reg.jal_addr;
    assign ds_o_reg_wr     = bundle_reg.reg_wr;
    assign ds_o_alu_src    = bundle_reg.alu_src;
    assign ds_o_memwrite   = bundle_reg.memwrite;
    assign ds_o_memtoreg   = bundle_reg.memtoreg;
    assign ds_o_branch     = bundle_reg.branch;
    assign ds_o_jal        = bundle_reg.jal;
    assign ds_o_jr         = bundle_reg.jr;
    assign ds_o_illegal    = bundle_reg.illegal;
    assign ds_o_bubble_cnt = cnt_reg;

endmodule

// File: tb/tb_decode_stage.sv
// Bench for decode_stage: directed scenarios plus randomized traffic against a
// transaction-level model, on two instances (JR_LINK_ONLY = 0 and 1).
module tb_decode_stage;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  wr;
        logic [31:0] imm;
        logic [25:0] jal_addr;
        logic        reg_wr;
        logic        alu_src;
        logic        memwrite;
        logic        memtoreg;
        logic        branch;
        logic        jal;
        logic        jr;
        logic        illegal;
    } bundle_t;

    localparam logic [31:0] I_LW      = 32'h8C24_0000; // lw  r4,0(r1)
    localparam logic [31:0] I_LW_R0   = 32'h8C20_0000; // lw  r0,0(r1)
    localparam logic [31:0] I_ADD_DEP = 32'h0087_3020; // add r6,r4,r7
    localparam logic [31:0] I_ADD_IND = 32'h0007_3020; // add r6,r0,r7

    logic        ds_clk, ds_rst, ds_i_valid, ds_i_flush, ds_i_ready;
    logic [31:0] ds_i_instr;

    logic        a_ready, a_valid, a_reg_wr, a_alu_src, a_memwrite, a_memtoreg, a_branch, a_jal, a_jr, a_illegal;
    logic [5:0]  a_opcode, a_funct;
    logic [4:0]  a_rs, a_rt, a_wr;
    logic [31:0] a_imm;
    logic [25:0] a_jal_addr;
    logic [15:0] a_cnt;

    logic        b_ready, b_valid, b_reg_wr, b_alu_src, b_memwrite, b_memtoreg, b_branch, b_jal, b_jr, b_illegal;
    logic [5:0]  b_opcode, b_funct;
    logic [4:0]  b_rs, b_rt, b_wr;
    logic [31:0] b_imm;
    logic [25:0] b_jal_addr;
    logic [15:0] b_cnt;

    bundle_t a_b, b_b;
    assign a_b = {a_valid, a_opcode, a_funct, a_rs, a_rt, a_wr, a_imm, a_jal_addr,
                  a_reg_wr, a_alu_src, a_memwrite, a_memtoreg, a_branch, a_jal, a_jr, a_illegal};
    assign b_b = {b_valid, b_opcode, b_funct, b_rs, b_rt, b_wr, b_imm, b_jal_addr,
                  b_reg_wr, b_alu_src, b_memwrite, b_memtoreg, b_branch, b_jal, b_jr, b_illegal};

    decode_stage #(.JR_LINK_ONLY(0)) dut (
        .ds_clk(ds_clk), .ds_rst(ds_rst), .ds_i_valid(ds_i_valid), .ds_o_ready(a_ready),
        .ds_i_instr(ds_i_instr), .ds_i_flush(ds_i_flush), .ds_i_ready(ds_i_ready),
        .ds_o_valid(a_valid), .ds_o_opcode(a_opcode), .ds_o_funct(a_funct),
        .ds_o_addr_rs(a_rs), .ds_o_addr_rt(a_rt), .ds_o_addr_wr(a_wr), .ds_o_imm(a_imm),
        .ds_o_jal_addr(a_jal_addr), .ds_o_reg_wr(a_reg_wr), .ds_o_alu_src(a_alu_src),
        .ds_o_memwrite(a_memwrite), .ds_o_memtoreg(a_memtoreg), .ds_o_branch(a_branch),
        .ds_o_jal(a_jal), .ds_o_jr(a_jr), .ds_o_illegal(a_illegal), .ds_o_bubble_cnt(a_cnt)
    );

    decode_stage #(.JR_LINK_ONLY(1)) dut_jl (
        .ds_clk(ds_clk), .ds_rst(ds_rst), .ds_i_valid(ds_i_valid), .ds_o_ready(b_ready),
        .ds_i_instr(ds_i_instr), .ds_i_flush(ds_i_flush), .ds_i_ready(ds_i_ready),
        .ds_o_valid(b_valid), .ds_o_opcode(b_opcode), .ds_o_funct(b_funct),
        .ds_o_addr_rs(b_rs), .ds_o_addr_rt(b_rt), .ds_o_addr_wr(b_wr), .ds_o_imm(b_imm),
        .ds_o_jal_addr(b_jal_addr), .ds_o_reg_wr(b_reg_wr), .ds_o_alu_src(b_alu_src),
        .ds_o_memwrite(b_memwrite), .ds_o_memtoreg(b_memtoreg), .ds_o_branch(b_branch),
        .ds_o_jal(b_jal), .ds_o_jr(b_jr), .ds_o_illegal(b_illegal), .ds_o_bubble_cnt(b_cnt)
    );

    initial ds_clk = 1'b0;
    always #5 ds_clk = ~ds_clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference state: the bundle each instance should be presenting, and its bubble count.
    bundle_t     exp_b   [2];
    logic [15:0] exp_cnt [2];

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return v[15] ? (32'(v) - 32'h0001_0000) : 32'(v);
    endfunction

    function automatic bundle_t ref_decode(input logic [31:0] ins, input bit jl);
        bundle_t b;
        logic [5:0] op;
        op = ins[31:26];
        b = '0;
        b.valid = 1'b1;
        case (op)
            6'h00: begin
                b.opcode = op; b.funct = ins[5:0]; b.rt = ins[20:16];
                if (ins[5:0] == 6'h08) begin
                    b.jr = 1'b1; b.rs = jl ? 5'd31 : ins[25:21];
                end else begin
                    b.rs = ins[25:21]; b.reg_wr = 1'b1; b.wr = ins[15:11];
                end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: begin
                b.opcode = op; b.rs = ins[25:21]; b.rt = ins[20:16]; b.wr = ins[20:16];
                b.imm = (op == 6'h0C || op == 6'h0D) ? 32'(ins[15:0]) : sext16(ins[15:0]);
                b.reg_wr = 1'b1; b.alu_src = 1'b1;
            end
            6'h04, 6'h05: begin
                b.opcode = op; b.rs = ins[25:21]; b.rt = ins[20:16];
                b.imm = sext16(ins[15:0]); b.branch = 1'b1;
            end
            6'h23: begin
                b.opcode = op; b.rs = ins[25:21]; b.rt = ins[20:16]; b.wr = ins[20:16];
                b.imm = sext16(ins[15:0]); b.reg_wr = 1'b1; b.alu_src = 1'b1; b.memtoreg = 1'b1;
            end
            6'h2B: begin
                b.opcode = op; b.rs = ins[25:21]; b.rt = ins[20:16];
                b.imm = sext16(ins[15:0]); b.alu_src = 1'b1; b.memwrite = 1'b1;
            end
            6'h03: begin
                b.opcode = op; b.jal_addr = ins[25:0]; b.wr = 5'd31; b.jal = 1'b1; b.reg_wr = 1'b1;
            end
            default: b.illegal = 1'b1;
        endcase
        return b;
    endfunction

    function automatic bit reads_reg(input logic [31:0] ins, input bit jl, input logic [4:0] r);
        logic [4:0] srcs[$];
        bit hit;
        hit = 1'b0;
        case (ins[31:26])
            6'h00: begin
                if (ins[5:0] == 6'h08) srcs.push_back(jl ? 5'd31 : ins[25:21]);
                else begin srcs.push_back(ins[25:21]); srcs.push_back(ins[20:16]); end
            end
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h23: srcs.push_back(ins[25:21]);
            6'h04, 6'h05, 6'h2B: begin srcs.push_back(ins[25:21]); srcs.push_back(ins[20:16]); end
            default: ;
        endcase
        foreach (srcs[i]) if (srcs[i] == r) hit = 1'b1;
        return hit;
    endfunction

    function automatic bit model_hazard(input int k);
        return exp_b[k].valid && exp_b[k].memtoreg && (exp_b[k].wr != 5'd0) && ds_i_valid
               && reads_reg(ds_i_instr, k == 1, exp_b[k].wr);
    endfunction

    function automatic bit model_ready(input int k);
        return ds_i_flush || (!(exp_b[k].valid && !ds_i_ready) && !model_hazard(k));
    endfunction

    // Advance the model across one clock edge together with the DUTs.
    task automatic tick();
        bundle_t     nb [2];
        logic [15:0] nc [2];
        for (int k = 0; k < 2; k++) begin
            nb[k] = exp_b[k];
            nc[k] = exp_cnt[k];
            if (ds_rst) begin
                nb[k] = '0; nc[k] = '0;
            end else if (ds_i_flush) begin
                nb[k] = '0;
            end else if (exp_b[k].valid && !ds_i_ready) begin
                nb[k] = exp_b[k];
            end else if (model_hazard(k)) begin
                nb[k] = '0;
                if (nc[k] != 16'hFFFF) nc[k] = nc[k] + 16'd1;
            end else if (ds_i_valid) begin
                nb[k] = ref_decode(ds_i_instr, k == 1);
            end else begin
                nb[k] = '0;
            end
        end
        @(posedge ds_clk);
        exp_b   = nb;
        exp_cnt = nc;
        #1;
    endtask

    task automatic pulse_reset();
        ds_rst = 1'b1; ds_i_valid = 1'b0; ds_i_flush = 1'b0; ds_i_ready = 1'b1;
        tick();
        ds_rst = 1'b0;
    endtask

    task automatic test_reset();
        ds_i_instr = 32'h0; exp_b[0] = '0; exp_b[1] = '0; exp_cnt[0] = '0; exp_cnt[1] = '0;
        pulse_reset();
        tick();
        $display("reset: valid=%b cnt=%0d ready=%b", a_valid, a_cnt, a_ready);
        n_cmp++; if (a_b !== '0) begin n_fail++; $display("FAIL reset_bundle: got %h want 0", a_b); end
        n_cmp++; if (a_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_cnt: got %0d want 0", a_cnt); end
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", a_ready); end
        n_cmp++; if (b_b !== '0) begin n_fail++; $display("FAIL reset_bundle_jl: got %h want 0", b_b); end
    endtask

    task automatic test_addi();
        bundle_t e;
        ds_i_valid = 1'b1; ds_i_instr = 32'h2022_FFFC; ds_i_ready = 1'b1;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL addi_ready: got %b want 1", a_ready); end
        tick();
        ds_i_valid = 1'b0;
        e = '0; e.valid = 1'b1; e.opcode = 6'h08; e.rs = 5'd1; e.rt = 5'd2; e.wr = 5'd2;
        e.imm = 32'hFFFF_FFFC; e.reg_wr = 1'b1; e.alu_src = 1'b1;
        $display("addi: valid=%b wr=%0d rs=%0d imm=%h", a_valid, a_wr, a_rs, a_imm);
        n_cmp++; if (a_b !== e) begin n_fail++; $display("FAIL addi_bundle: got %h want %h", a_b, e); end
        tick();
    endtask

    task automatic test_imm_ops();
        bundle_t e;
        ds_i_ready = 1'b1; ds_i_valid = 1'b1; ds_i_instr = 32'h3403_8000; // ori r3,r0,0x8000
        tick();
        ds_i_instr = 32'h0C00_0040; // jal 0x40
        e = '0; e.valid = 1'b1; e.opcode = 6'h0D; e.rt = 5'd3; e.wr = 5'd3; e.imm = 32'h0000_8000;
        e.reg_wr = 1'b1; e.alu_src = 1'b1;
        $display("ori: valid=%b wr=%0d imm=%h", a_valid, a_wr, a_imm);
        n_cmp++; if (a_b !== e) begin n_fail++; $display("FAIL ori_bundle: got %h want %h", a_b, e); end
        tick();
        ds_i_instr = 32'h00A0_0008; // jr r5
        e = '0; e.valid = 1'b1; e.opcode = 6'h03; e.jal_addr = 26'h40; e.wr = 5'd31;
        e.jal = 1'b1; e.reg_wr = 1'b1;
        $display("jal: valid=%b wr=%0d jal_addr=%h", a_valid, a_wr, a_jal_addr);
        n_cmp++; if (a_b !== e) begin n_fail++; $display("FAIL jal_bundle: got %h want %h", a_b, e); end
        tick();
        ds_i_valid = 1'b0;
        $display("jr: rs=%0d rs_link_only=%0d jr=%b", a_rs, b_rs, a_jr);
        n_cmp++; if ({a_valid, a_jr, a_reg_wr, a_rs, a_wr} !== {1'b1, 1'b1, 1'b0, 5'd5, 5'd0}) begin
            n_fail++; $display("FAIL jr_rs: got v=%b jr=%b rw=%b rs=%0d wr=%0d want 1 1 0 5 0",
                               a_valid, a_jr, a_reg_wr, a_rs, a_wr);
        end
        n_cmp++; if ({b_jr, b_rs} !== {1'b1, 5'd31}) begin
            n_fail++; $display("FAIL jr_link_only_rs: got jr=%b rs=%0d want 1 31", b_jr, b_rs);
        end
        tick();
    endtask

    task automatic test_load_use();
        pulse_reset();
        ds_i_valid = 1'b1; ds_i_instr = I_LW;
        tick();
        ds_i_instr = I_ADD_DEP;
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL load_use_ready_low: got %b want 0", a_ready); end
        tick();
        $display("load_use bubble: valid=%b cnt=%0d ready=%b", a_valid, a_cnt, a_ready);
        n_cmp++; if (a_b !== '0) begin n_fail++; $display("FAIL load_use_bubble: got %h want 0", a_b); end
        n_cmp++; if (a_cnt !== 16'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d want 1", a_cnt); end
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL load_use_ready_back: got %b want 1", a_ready); end
        tick();
        $display("load_use add: valid=%b wr=%0d rs=%0d", a_valid, a_wr, a_rs);
        n_cmp++; if ({a_valid, a_wr, a_rs, a_rt, a_reg_wr} !== {1'b1, 5'd6, 5'd4, 5'd7, 1'b1}) begin
            n_fail++; $display("FAIL load_use_add: got v=%b wr=%0d rs=%0d rt=%0d want 1 6 4 7", a_valid, a_wr, a_rs, a_rt);
        end
        ds_i_instr = I_LW;
        tick();
        ds_i_instr = I_ADD_IND;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL no_hazard_ready: got %b want 1", a_ready); end
        tick();
        ds_i_instr = I_LW_R0;
        $display("no_hazard add: valid=%b wr=%0d cnt=%0d", a_valid, a_wr, a_cnt);
        n_cmp++; if ({a_valid, a_wr, a_cnt} !== {1'b1, 5'd6, 16'd1}) begin
            n_fail++; $display("FAIL no_hazard_add: got v=%b wr=%0d cnt=%0d want 1 6 1", a_valid, a_wr, a_cnt);
        end
        tick();
        ds_i_instr = I_ADD_IND;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL load_r0_ready: got %b want 1", a_ready); end
        tick();
        ds_i_valid = 1'b0;
        tick();
    endtask

    task automatic test_backpressure();
        bundle_t e;
        pulse_reset();
        ds_i_valid = 1'b1; ds_i_instr = I_LW;
        tick();
        ds_i_instr = I_ADD_DEP; ds_i_ready = 1'b0;
        e = '0; e.valid = 1'b1; e.opcode = 6'h23; e.rs = 5'd1; e.rt = 5'd4; e.wr = 5'd4;
        e.reg_wr = 1'b1; e.alu_src = 1'b1; e.memtoreg = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready: cycle %0d got %b want 0", c, a_ready); end
            tick();
            $display("backpressure %0d: valid=%b cnt=%0d", c, a_valid, a_cnt);
            n_cmp++; if ({a_b, a_cnt} !== {e, 16'd0}) begin
                n_fail++; $display("FAIL bp_hold: cycle %0d got %h/%0d want %h/0", c, a_b, a_cnt, e);
            end
        end
        ds_i_ready = 1'b1;
        #1;
        n_cmp++; if (a_ready !== 1'b0) begin n_fail++; $display("FAIL bp_release_ready: got %b want 0", a_ready); end
        tick();
        n_cmp++; if ({a_valid, a_cnt} !== {1'b0, 16'd1}) begin
            n_fail++; $display("FAIL bp_release_bubble: got v=%b cnt=%0d want 0 1", a_valid, a_cnt);
        end
        tick();
        ds_i_valid = 1'b0;
        $display("backpressure release: valid=%b wr=%0d", a_valid, a_wr);
        n_cmp++; if ({a_valid, a_wr} !== {1'b1, 5'd6}) begin
            n_fail++; $display("FAIL bp_release_add: got v=%b wr=%0d want 1 6", a_valid, a_wr);
        end
        tick();
    endtask

    task automatic test_flush();
        pulse_reset();
        ds_i_valid = 1'b1; ds_i_instr = I_LW;
        tick();
        ds_i_ready = 1'b0; ds_i_instr = I_ADD_DEP; ds_i_flush = 1'b1;
        #1;
        n_cmp++; if (a_ready !== 1'b1) begin n_fail++; $display("FAIL flush_ready: got %b want 1", a_ready); end
        tick();
        ds_i_flush = 1'b0; ds_i_valid = 1'b0; ds_i_ready = 1'b1;
        $display("flush held: valid=%b reg_wr=%b", a_valid, a_reg_wr);
        n_cmp++; if (a_b !== '0) begin n_fail++; $display("FAIL flush_held: got %h want 0", a_b); end
        tick();
        n_cmp++; if (a_b !== '0) begin n_fail++; $display("FAIL flush_discard: got %h want 0", a_b); end
        ds_i_valid = 1'b1; ds_i_instr = I_LW;
        tick();
        ds_i_instr = I_ADD_DEP; ds_i_flush = 1'b1;
        tick();
        ds_i_flush = 1'b0; ds_i_valid = 1'b0;
        $display("flush+hazard: valid=%b cnt=%0d", a_valid, a_cnt);
        n_cmp++; if ({a_b, a_cnt} !== {bundle_t'('0), 16'd0}) begin
            n_fail++; $display("FAIL flush_hazard: got %h/%0d want 0/0", a_b, a_cnt);
        end
        tick();
    endtask

    task automatic test_illegal();
        bundle_t e;
        logic [25:0] low;
        low = 26'($urandom);
        ds_i_valid = 1'b1; ds_i_instr = {6'h3F, low};
        tick();
        ds_i_valid = 1'b0;
        e = '0; e.valid = 1'b1; e.illegal = 1'b1;
        $display("illegal: instr=%h valid=%b illegal=%b", {6'h3F, low}, a_valid, a_illegal);
        n_cmp++; if (a_b !== e) begin n_fail++; $display("FAIL illegal_bundle: got %h want %h", a_b, e); end
        tick();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [4:0]  ra, rb, rd;
        logic [5:0]  fn, op;
        logic [15:0] im;
        ra = 5'($urandom_range(0, 7)); rb = 5'($urandom_range(0, 7)); rd = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        fn = 6'($urandom);
        if (fn == 6'h08) fn = 6'h20;
        case ($urandom_range(0, 9))
            0, 9: return {6'h00, ra, rb, rd, 5'd0, fn};
            1: return {6'h00, ra, 15'd0, 6'h08};
            2: begin op = 6'h08 + 6'($urandom_range(0, 5)); return {op, ra, rb, im}; end
            3, 4: return {6'h23, ra, rb, im};
            5: return {6'h2B, ra, rb, im};
            6: begin op = 6'h04 + 6'($urandom_range(0, 1)); return {op, ra, rb, im}; end
            7: return {6'h03, 26'($urandom)};
            default: begin
                case ($urandom_range(0, 3))
                    0: op = 6'h02;
                    1: op = 6'h10;
                    2: op = 6'h20;
                    default: op = 6'h3F;
                endcase
                return {op, ra, rb, im};
            end
        endcase
    endfunction

    task automatic test_random();
        for (int c = 0; c < 500; c++) begin
            ds_rst     = ($urandom_range(0, 199) == 0);
            ds_i_flush = ($urandom_range(0, 15) == 0);
            ds_i_valid = ($urandom_range(0, 4) != 0);
            ds_i_ready = ($urandom_range(0, 3) != 0);
            ds_i_instr = rand_instr();
            #1;
            $display("rand %0d: instr=%h v=%b r=%b f=%b rst=%b ready=%b out_v=%b cnt=%0d",
                     c, ds_i_instr, ds_i_valid, ds_i_ready, ds_i_flush, ds_rst, a_ready, a_valid, a_cnt);
            n_cmp++;
            if ({a_ready, a_b, a_cnt} !== {model_ready(0), exp_b[0], exp_cnt[0]}) begin
                n_fail++; $display("FAIL rand_link0: cycle %0d got %b/%h/%0d want %b/%h/%0d", c,
                                   a_ready, a_b, a_cnt, model_ready(0), exp_b[0], exp_cnt[0]);
            end
            n_cmp++;
            if ({b_ready, b_b, b_cnt} !== {model_ready(1), exp_b[1], exp_cnt[1]}) begin
                n_fail++; $display("FAIL rand_link1: cycle %0d got %b/%h/%0d want %b/%h/%0d", c,
                                   b_ready, b_b, b_cnt, model_ready(1), exp_b[1], exp_cnt[1]);
            end
            tick();
        end
        ds_rst = 1'b0; ds_i_flush = 1'b0; ds_i_valid = 1'b0; ds_i_ready = 1'b1;
    endtask

    initial begin
        ds_rst = 1'b1; ds_i_valid = 1'b0; ds_i_flush = 1'b0; ds_i_ready = 1'b1; ds_i_instr = '0;
        test_reset();
        test_addi();
        test_imm_ops();
        test_load_use();
        test_backpressure();
        test_flush();
        test_illegal();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
